// File: rtl/udp_audio_pkg.sv
// Shared definitions for the UDP audio receive path.
// Holds the playback state encoding, sample and statistics-counter widths,
// and the byte order of samples carried in the UDP payload.
package udp_audio_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned CNT_W    = 16;

   // 1: first payload byte of a sample is its high byte.
   localparam bit BYTE_ORDER_BE = 1'b1;

   typedef enum logic {
      ST_PREFILL = 1'b0,
      ST_PLAY    = 1'b1
   } state_t;

endpackage

// File: rtl/udp_audio_ram.sv
// Simple dual-port sample RAM with one write port and one registered read port.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read port;
// rd_clr zeroes the read register (takes priority over rd_en); rd_data is the
// registered read data, which holds its value between reads.
module udp_audio_ram #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port with synchronous clear of the output register.
   always_ff @(posedge clk) begin
      if (rd_clr)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/udp_audio_rx.sv
// UDP payload to DAC sample path: packs payload bytes into 16-bit samples,
// buffers them in a circular RAM and plays one out per DAC request.
// Ports: sys_clk, rst_n (sync, active-low); rec_en/rec_data/rec_pkt_done
// payload byte stream; sample_req DAC request strobe; dac_data/dac_valid
// playback sample; fifo_level buffered sample count; playing high in PLAY;
// overflow_cnt/underrun_cnt saturating drop and underrun statistics.
module udp_audio_rx
   import udp_audio_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned PREFILL = 256
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                rec_en,
   input  logic [7:0]          rec_data,
   input  logic                rec_pkt_done,
   input  logic                sample_req,
   output logic [SAMPLE_W-1:0] dac_data,
   output logic                dac_valid,
   output logic [ADDR_W:0]     fifo_level,
   output logic                playing,
   output logic [CNT_W-1:0]    overflow_cnt,
   output logic [CNT_W-1:0]    underrun_cnt
);

   localparam int unsigned LVL_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   state_t              state, state_next;
   logic                phase;
   logic [7:0]          hi_byte;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [SAMPLE_W-1:0] sample;
   logic                sample_done, full, wr_do, ovf_inc;
   logic                pop, serve_zero, unr_inc;

   // Byte packer: a sample completes on the second byte of a pair.
   assign sample_done = rec_en & phase;
   assign sample      = BYTE_ORDER_BE ? {hi_byte, rec_data} : {rec_data, hi_byte};
   assign full        = (fifo_level == LVL_W'(DEPTH));
   assign wr_do       = sample_done & ~full;
   assign ovf_inc     = sample_done & full;

   // Packet end clears the phase after the same-cycle byte has been used.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         phase   <= 1'b0;
         hi_byte <= '0;
      end else begin
         if (rec_en && !phase) hi_byte <= rec_data;
         if (rec_pkt_done)     phase <= 1'b0;
         else if (rec_en)      phase <= ~phase;
      end
   end

   // Playback FSM next-state and request decode.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      serve_zero = 1'b0;
      unr_inc    = 1'b0;
      case (state)
         ST_PREFILL: begin
            if (sample_req) serve_zero = 1'b1;
            if (fifo_level >= LVL_W'(PREFILL)) state_next = ST_PLAY;
         end
         ST_PLAY: begin
            if (sample_req) begin
               if (fifo_level != '0) begin
                  pop = 1'b1;
               end else begin
                  serve_zero = 1'b1;
                  unr_inc    = 1'b1;
                  state_next = ST_PREFILL;
               end
            end
         end
         default: state_next = ST_PREFILL;
      endcase
   end

   // State, pointers, level and output strobes.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state      <= ST_PREFILL;
         playing    <= 1'b0;
         dac_valid  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         state     <= state_next;
         playing   <= (state_next == ST_PLAY);
         dac_valid <= sample_req;
         if (wr_do) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_do, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
         underrun_cnt <= '0;
      end else begin
         if (ovf_inc && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
         if (unr_inc && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
   end

   // The RAM read register doubles as the dac_data output register.
   udp_audio_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (SAMPLE_W)
   ) u_ram (
      .clk     (sys_clk),
      .wr_en   (wr_do),
      .wr_addr (wr_ptr),
      .wr_data (sample),
      .rd_en   (pop),
      .rd_clr  (~rst_n | serve_zero),
      .rd_addr (rd_ptr),
      .rd_data (dac_data)
   );

endmodule

// File: tb/tb_udp_audio_rx.sv
// Directed bench for udp_audio_rx with ADDR_W=10, PREFILL=256.
module tb_udp_audio_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rec_en = 1'b0;
   logic [7:0]  rec_data = '0;
   logic        rec_pkt_done = 1'b0;
   logic        sample_req = 1'b0;
   logic [15:0] dac_data;
   logic        dac_valid;
   logic [10:0] fifo_level;
   logic        playing;
   logic [15:0] overflow_cnt;
   logic [15:0] underrun_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   udp_audio_rx #(.ADDR_W(10), .PREFILL(256)) dut (
      .sys_clk      (clk),
      .rst_n        (rst_n),
      .rec_en       (rec_en),
      .rec_data     (rec_data),
      .rec_pkt_done (rec_pkt_done),
      .sample_req   (sample_req),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .fifo_level   (fifo_level),
      .playing      (playing),
      .overflow_cnt (overflow_cnt),
      .underrun_cnt (underrun_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One byte in the cycle after the current negedge; returns at the next negedge.
   task automatic send_byte(input logic [7:0] b, input logic done);
      rec_en       = 1'b1;
      rec_data     = b;
      rec_pkt_done = done;
      @(negedge clk);
      rec_en       = 1'b0;
      rec_pkt_done = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] s);
      send_byte(s[15:8], 1'b0);
      send_byte(s[7:0], 1'b0);
   endtask

   // Idle cycle, one-cycle request, then check the response one cycle later.
   task automatic request(input string tag, input logic [15:0] exp);
      @(negedge clk);
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      check({tag, " valid"}, 32'(dac_valid), 32'd1);
      check(tag, 32'(dac_data), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst dac_data", 32'(dac_data), 0);
      check("rst dac_valid", 32'(dac_valid), 0);
      check("rst level", 32'(fifo_level), 0);
      check("rst playing", 32'(playing), 0);
      check("rst ovf", 32'(overflow_cnt), 0);
      check("rst unr", 32'(underrun_cnt), 0);

      // Requests while empty in PREFILL give zeros
      for (int i = 0; i < 4; i++) request("prefill zero", 16'h0000);
      @(negedge clk);
      check("prefill valid drop", 32'(dac_valid), 0);
      check("prefill playing", 32'(playing), 0);
      check("prefill level", 32'(fifo_level), 0);

      // Fill to PREFILL; a request in the reaching cycle is still served as zero
      for (int i = 0; i < 256; i++) send_sample(16'(i));
      check("fill level", 32'(fifo_level), 256);
      check("fill playing pre", 32'(playing), 0);
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      check("edge req valid", 32'(dac_valid), 1);
      check("edge req data", 32'(dac_data), 0);
      check("edge playing", 32'(playing), 1);
      check("edge level", 32'(fifo_level), 256);
      for (int i = 0; i < 256; i++) request("play seq", 16'(i));
      check("drain level", 32'(fifo_level), 0);
      check("drain playing", 32'(playing), 1);

      // Underrun
      request("underrun data", 16'h0000);
      check("underrun cnt", 32'(underrun_cnt), 1);
      check("underrun playing", 32'(playing), 0);

      // Packing: odd byte discarded at packet end, done on completing byte keeps sample
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      send_byte(8'h78, 1'b0);
      send_byte(8'h9A, 1'b1);
      send_byte(8'hAB, 1'b0);
      send_byte(8'hCD, 1'b1);
      check("pack level", 32'(fifo_level), 3);
      for (int i = 0; i < 253; i++) send_sample(16'h1000 + 16'(i));
      @(negedge clk);
      check("pack playing", 32'(playing), 1);
      request("pack s0", 16'h1234);
      request("pack s1", 16'h5678);
      request("pack s2", 16'hABCD);
      for (int i = 0; i < 253; i++) request("pack tail", 16'h1000 + 16'(i));
      check("pack drained", 32'(fifo_level), 0);

      // Write and pop in the same cycle at level 300
      for (int i = 0; i < 300; i++) send_sample(16'h2000 + 16'(i));
      check("coinc level pre", 32'(fifo_level), 300);
      send_byte(8'h5A, 1'b0);
      rec_en     = 1'b1;
      rec_data   = 8'hA5;
      sample_req = 1'b1;
      @(negedge clk);
      rec_en     = 1'b0;
      sample_req = 1'b0;
      check("coinc valid", 32'(dac_valid), 1);
      check("coinc data", 32'(dac_data), 32'h2000);
      check("coinc level", 32'(fifo_level), 300);
      for (int i = 1; i < 300; i++) request("coinc seq", 16'h2000 + 16'(i));
      request("coinc new", 16'h5AA5);
      check("coinc drained", 32'(fifo_level), 0);

      // Overflow with wrapped pointers
      for (int i = 0; i < 1030; i++) send_sample(16'(i));
      check("ovf level", 32'(fifo_level), 1024);
      check("ovf cnt", 32'(overflow_cnt), 6);
      for (int i = 0; i < 1024; i++) request("ovf seq", 16'(i));
      check("ovf drained", 32'(fifo_level), 0);
      request("ovf underrun", 16'h0000);
      check("underrun cnt 2", 32'(underrun_cnt), 2);

      // Reset mid-stream
      for (int i = 0; i < 5; i++) send_sample(16'h7000 + 16'(i));
      rec_en     = 1'b1;
      rec_data   = 8'h11;
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      rec_data   = 8'h22;
      rst_n      = 1'b0;
      @(negedge clk);
      rec_en = 1'b0;
      check("mid rst valid", 32'(dac_valid), 0);
      check("mid rst data", 32'(dac_data), 0);
      check("mid rst level", 32'(fifo_level), 0);
      check("mid rst playing", 32'(playing), 0);
      check("mid rst ovf", 32'(overflow_cnt), 0);
      check("mid rst unr", 32'(underrun_cnt), 0);
      rst_n = 1'b1;
      request("post rst zero", 16'h0000);
      check("post rst level", 32'(fifo_level), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
